// File: rtl/fsm_mealy_stim_driver_pkg.sv
// Shared encodings and transition function for the 4-state Mealy FSM and its stimulus driver.
// Pure types and functions; no timing or flow control lives here.
package fsm_mealy_stim_driver_pkg;

  typedef enum logic [1:0] {S0 = 2'd0, S1 = 2'd1, S2 = 2'd2, S3 = 2'd3} ystate_t;
  typedef enum logic {IDLE = 1'b0, DRIVE = 1'b1} ctrl_t;

  function automatic ystate_t mealy_next(input ystate_t y, input logic a);
    ystate_t n;
    case (y)
      S0:      n = a ? S3 : S0;
      S1:      n = a ? S0 : S1;
      S2:      n = a ? S1 : S2;
      default: n = a ? S1 : S2;
    endcase
    return n;
  endfunction

  // Only s3 has a choice: drop straight to s2, or go through s1 toward s0/s1/s3.
  function automatic logic hop_bit(input ystate_t y, input ystate_t target);
    return (y == S3) ? (target != S2) : 1'b1;
  endfunction

endpackage

// File: rtl/fsm_mealy_model.sv
// Tracked copy of the downstream Mealy FSM: state register plus combinational Z.
// State advances every clock edge from a_i; Z follows a_i with zero latency; no flow control.
module fsm_mealy_model
  import fsm_mealy_stim_driver_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       a_i,
  output logic [1:0] y_o,
  output logic       z_o
);

  ystate_t y_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) y_q <= S0;
    else      y_q <= mealy_next(y_q, a_i);
  end

  assign y_o = y_q;
  assign z_o = a_i && ((y_q == S0) || (y_q == S1));

endmodule

// File: rtl/fsm_mealy_stim_driver.sv
// Drives serial bit A so the downstream Mealy FSM reaches a requested state, pulsing done on arrival.
// done in cycle k+1 after accept (k <= 3 hops); req_ready low while busy, requests are dropped, not queued.
module fsm_mealy_stim_driver
  import fsm_mealy_stim_driver_pkg::*;
#(
  parameter logic        HOLD_A   = 1'b0,
  parameter int unsigned MAX_HOPS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [1:0] req_target,
  output logic       req_ready,
  output logic       A,
  output logic [1:0] y_model,
  output logic       Z_model,
  output logic       busy,
  output logic       done,
  output logic [1:0] steps
);

  localparam logic [1:0] MAX_Q = 2'(MAX_HOPS);

  ctrl_t      state_q,  state_d;
  ystate_t    target_q, target_d;
  logic [1:0] steps_q,  steps_d;
  logic [1:0] y_w;

  fsm_mealy_model u_model (
    .clk (clk),
    .rst (rst),
    .a_i (A),
    .y_o (y_w),
    .z_o (Z_model)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      target_q <= S0;
      steps_q  <= 2'd0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      steps_q  <= steps_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    steps_d   = steps_q;
    A         = HOLD_A;
    req_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_d  = DRIVE;
          target_d = ystate_t'(req_target);
          steps_d  = 2'd0;
        end
      end
      default: begin
        busy = 1'b1;
        if (y_w == target_q) begin
          done    = 1'b1;
          state_d = IDLE;
        end else begin
          A = hop_bit(ystate_t'(y_w), target_q);
          if (steps_q != MAX_Q) steps_d = steps_q + 2'd1;
        end
      end
    endcase
  end

  assign y_model = y_w;
  assign steps   = steps_q;

endmodule

// File: tb/tb_fsm_mealy_stim_driver.sv
// Self-checking bench for fsm_mealy_stim_driver: per-cycle scoreboard of A/y/Z/done plus spec-level latency and hop patterns.
module tb_fsm_mealy_stim_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_valid = 1'b0;
  logic [1:0] req_target = 2'd0;
  logic       req_ready, A, Z_model, busy, done;
  logic [1:0] y_model, steps;
  logic [1:0] ref_y;
  logic       ref_z;

  int errors = 0;
  int checks = 0;
  logic [1:0] m_y = 2'd0;

  typedef struct packed {
    logic       a;
    logic [1:0] y;
    logic       z;
    logic       dn;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  fsm_mealy_stim_driver dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_target(req_target),
    .req_ready(req_ready), .A(A), .y_model(y_model), .Z_model(Z_model),
    .busy(busy), .done(done), .steps(steps)
  );

  fsm_mealy_model u_ref (.clk(clk), .rst(rst), .a_i(A), .y_o(ref_y), .z_o(ref_z));

  function automatic logic [1:0] tb_next(input logic [1:0] y, input logic a);
    case (y)
      2'd0:    return a ? 2'd3 : 2'd0;
      2'd1:    return a ? 2'd0 : 2'd1;
      2'd2:    return a ? 2'd1 : 2'd2;
      default: return a ? 2'd1 : 2'd2;
    endcase
  endfunction

  function automatic logic tb_hop(input logic [1:0] y, input logic [1:0] t);
    if (y == 2'd3 && t == 2'd2) return 1'b0;
    return 1'b1;
  endfunction

  // A hop while the counter is already saturated should never happen for legal requests.
  always @(negedge clk) begin
    if (rst && busy && !done && steps == 2'd3) begin
      errors++;
      $display("FAIL sat_hop: hop requested with steps=%0d, required none", steps);
    end
  end

  task automatic do_request(input logic [1:0] tgt, input int exp_k, input logic [1:0] exp_steps,
                            input logic [3:0] exp_aseq, input bit hold_next, input logic [1:0] next_tgt);
    logic [1:0] y;
    logic       a;
    logic [3:0] aseq;
    int         cyc;
    bit         fin;
    exp_t       e;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL req_ready_idle: got %b want 1", req_ready);
    end
    sb.delete();
    y = tb_next(m_y, 1'b0);
    for (int k = 0; k < 8 && y != tgt; k++) begin
      a = tb_hop(y, tgt);
      sb.push_back('{a: a, y: y, z: a && (y < 2'd2), dn: 1'b0});
      y = tb_next(y, a);
    end
    sb.push_back('{a: 1'b0, y: y, z: 1'b0, dn: 1'b1});
    req_valid  = 1'b1;
    req_target = tgt;
    @(negedge clk);
    req_valid = hold_next;
    if (hold_next) req_target = next_tgt;
    cyc = 0; fin = 0; aseq = 4'd0;
    while (!fin) begin
      cyc++;
      if (sb.size() == 0 || cyc > 8) begin
        errors++; $display("FAIL done_timeout: tgt=%0d no done after %0d cycles", tgt, cyc);
        fin = 1;
      end else begin
        e = sb.pop_front();
        checks++;
        if (A !== e.a) begin errors++; $display("FAIL a_bit: tgt=%0d cyc=%0d got %b want %b", tgt, cyc, A, e.a); end
        checks++;
        if (y_model !== e.y) begin errors++; $display("FAIL y_model: tgt=%0d cyc=%0d got %0d want %0d", tgt, cyc, y_model, e.y); end
        checks++;
        if (ref_y !== e.y) begin errors++; $display("FAIL ref_y: tgt=%0d cyc=%0d got %0d want %0d", tgt, cyc, ref_y, e.y); end
        checks++;
        if (Z_model !== e.z) begin errors++; $display("FAIL z_model: tgt=%0d cyc=%0d got %b want %b", tgt, cyc, Z_model, e.z); end
        checks++;
        if (done !== e.dn) begin errors++; $display("FAIL done: tgt=%0d cyc=%0d got %b want %b", tgt, cyc, done, e.dn); end
        checks++;
        if (busy !== 1'b1 || req_ready !== 1'b0) begin
          errors++; $display("FAIL drive_flags: tgt=%0d cyc=%0d busy=%b ready=%b want 1/0", tgt, cyc, busy, req_ready);
        end
        if (e.dn) begin
          fin = 1;
          checks++;
          if (cyc != exp_k + 1) begin errors++; $display("FAIL latency: tgt=%0d got %0d want %0d", tgt, cyc, exp_k + 1); end
          checks++;
          if (steps !== exp_steps) begin errors++; $display("FAIL steps: tgt=%0d got %0d want %0d", tgt, steps, exp_steps); end
          checks++;
          if (aseq !== exp_aseq) begin errors++; $display("FAIL a_pattern: tgt=%0d got %b want %b", tgt, aseq, exp_aseq); end
        end else begin
          aseq = {aseq[2:0], A};
          @(negedge clk);
        end
      end
    end
    m_y = tgt;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || req_ready !== 1'b1 || done !== 1'b0 || A !== 1'b0) begin
      errors++; $display("FAIL post_idle: busy=%b ready=%b done=%b A=%b want 0/1/0/0", busy, req_ready, done, A);
    end
    checks++;
    if (y_model !== tb_next(tgt, 1'b0)) begin
      errors++; $display("FAIL post_y: got %0d want %0d", y_model, tb_next(tgt, 1'b0));
    end
    checks++;
    if (steps !== exp_steps) begin errors++; $display("FAIL post_steps: got %0d want %0d", steps, exp_steps); end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (y_model !== 2'd0 || steps !== 2'd0 || A !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: y=%0d steps=%0d A=%b done=%b busy=%b ready=%b want 0/0/0/0/0/1",
               y_model, steps, A, done, busy, req_ready);
    end
    rst = 1'b1;
    m_y = 2'd0;
  endtask

  task automatic test_idle();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (y_model !== 2'd0 || A !== 1'b0 || done !== 1'b0 || req_ready !== 1'b1) begin
        errors++; $display("FAIL idle: cyc=%0d y=%0d A=%b done=%b ready=%b want 0/0/0/1", i, y_model, A, done, req_ready);
      end
    end
  endtask

  task automatic test_s0_to_s2();
    do_request(2'd2, 2, 2'd2, 4'b0010, 1'b0, 2'd0);
  endtask

  task automatic test_s1_to_s2();
    do_request(2'd0, 2, 2'd2, 4'b0011, 1'b0, 2'd0);
    do_request(2'd1, 2, 2'd2, 4'b0011, 1'b0, 2'd0);
    do_request(2'd2, 3, 2'd3, 4'b0110, 1'b0, 2'd0);
  endtask

  task automatic test_target_s3();
    do_request(2'd0, 2, 2'd2, 4'b0011, 1'b0, 2'd0);
    do_request(2'd3, 1, 2'd1, 4'b0001, 1'b0, 2'd0);
  endtask

  task automatic test_back_to_back();
    do_request(2'd0, 2, 2'd2, 4'b0011, 1'b1, 2'd1);
    do_request(2'd1, 2, 2'd2, 4'b0011, 1'b0, 2'd0);
  endtask

  task automatic test_reset_abort();
    req_valid  = 1'b1;
    req_target = 2'd3;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || y_model !== 2'd0) begin
      errors++; $display("FAIL abort_pre: busy=%b y=%0d want 1/0", busy, y_model);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (y_model !== 2'd0 || busy !== 1'b0 || done !== 1'b0 || req_ready !== 1'b1 || A !== 1'b0) begin
      errors++; $display("FAIL abort_now: y=%0d busy=%b done=%b ready=%b A=%b want 0/0/0/1/0", y_model, busy, done, req_ready, A);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || y_model !== 2'd0) begin
        errors++; $display("FAIL abort_hold: cyc=%0d done=%b busy=%b y=%0d want 0/0/0", i, done, busy, y_model);
      end
    end
    rst = 1'b1;
    m_y = 2'd0;
    do_request(2'd0, 0, 2'd0, 4'b0000, 1'b0, 2'd0);
  endtask

  initial begin
    test_reset();
    test_idle();
    test_s0_to_s2();
    test_s1_to_s2();
    test_target_s3();
    test_back_to_back();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
